regwrite_arbiter: RTL and testbench

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

---
 rtl/regwrite_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_regwrite_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: merges pipeline writeback and buffered multiply/divide results
// onto the single register-file write port. Pipeline writes normally win.
// Optional starvation guard: define WBARB_STARVE_GUARD_EN to force the buffer head
// through (stalling the pipeline for one cycle) after STARVE_LIMIT waiting cycles.
`timescale 1ns/1ps
module regwrite_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_regwrite,
    input  logic        wb_memtoreg,
    input  logic [31:0] wb_readdata,
    input  logic [31:0] wb_aluresult,
    input  logic [4:0]  wb_dst,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_dst,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
`ifdef WBARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
`endif

    // Elaboration-time parameter sanity checks
    generate
        if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
            $error("regwrite_arbiter: DEPTH must be 2 or 4");
        end
        if (STARVE_LIMIT < 1) begin : g_bad_limit
            $error("regwrite_arbiter: STARVE_LIMIT must be at least 1");
        end
    endgenerate

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1
`ifdef WBARB_STARVE_GUARD_EN
        ,
        ST_FORCE   = 2'd2
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               rf_we_q, rf_we_d;
    logic [4:0]         rf_waddr_q, rf_waddr_d;
    logic [31:0]        rf_wdata_q, rf_wdata_d;
    entry_t             buf_mem_q [DEPTH];
`ifdef WBARB_STARVE_GUARD_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pipe_stall_q, pipe_stall_d;
`endif

    logic               pipe_req_c;
    logic [31:0]        pipe_wdata_c;
    logic               buf_empty_c;
    logic               buf_full_c;
    logic               push_c;
    logic               force_c;
    logic               head_grant_c;
    logic               pipe_grant_c;
    entry_t             head_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request decode, buffer status and grant selection
    assign pipe_req_c   = wb_regwrite && (wb_dst != 5'd0);
    assign pipe_wdata_c = wb_memtoreg ? wb_readdata : wb_aluresult;
    assign buf_empty_c  = (occ_q == '0);
    assign buf_full_c   = (occ_q == OCC_W'(DEPTH));
    assign mdu_ready    = !buf_full_c;
    assign push_c       = mdu_valid && !buf_full_c && (mdu_dst != 5'd0);
    assign head_c       = buf_mem_q[rd_ptr_q];
`ifdef WBARB_STARVE_GUARD_EN
    assign force_c      = (state_q == ST_FORCE);
`else
    assign force_c      = 1'b0;
`endif
    assign head_grant_c = !buf_empty_c && (force_c || !pipe_req_c);
    assign pipe_grant_c = pipe_req_c && !force_c;

    // Next-state: pointers, occupancy, wait counter, FSM and write port
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
`ifdef WBARB_STARVE_GUARD_EN
        cnt_d        = '0;
        pipe_stall_d = 1'b0;
`endif

        if (push_c) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (head_grant_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push_c, head_grant_c})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (head_grant_c) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_c.dst;
            rf_wdata_d = head_c.data;
        end else if (pipe_grant_c) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_dst;
            rf_wdata_d = pipe_wdata_c;
        end

`ifdef WBARB_STARVE_GUARD_EN
        if (!buf_empty_c && !head_grant_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (push_c) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (occ_d == '0) begin
                    state_d = ST_IDLE;
                end
`ifdef WBARB_STARVE_GUARD_EN
                else if (cnt_d == CNT_W'(STARVE_LIMIT)) begin
                    state_d = ST_FORCE;
                end
`endif
            end
`ifdef WBARB_STARVE_GUARD_EN
            ST_FORCE: begin
                state_d = (occ_d == '0) ? ST_IDLE : ST_PENDING;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef WBARB_STARVE_GUARD_EN
        pipe_stall_d = (state_d == ST_FORCE);
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
`ifdef WBARB_STARVE_GUARD_EN
            cnt_q        <= '0;
            pipe_stall_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
`ifdef WBARB_STARVE_GUARD_EN
            cnt_q        <= cnt_d;
            pipe_stall_q <= pipe_stall_d;
`endif
        end
    end

    // Buffer storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (push_c) begin
            buf_mem_q[wr_ptr_q] <= {mdu_dst, mdu_data};
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
`ifdef WBARB_STARVE_GUARD_EN
    assign pipe_stall = pipe_stall_q;
`else
    assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Testbench for regwrite_arbiter: queue-based reference model feeding a scoreboard,
// with an independent monitor checking every register-file write and hold cycle.
`timescale 1ns/1ps
module tb_regwrite_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned DEPTH        = 2;
`ifdef WBARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_regwrite = 1'b0;
    logic        wb_memtoreg = 1'b0;
    logic [31:0] wb_readdata = '0;
    logic [31:0] wb_aluresult = '0;
    logic [4:0]  wb_dst = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_dst = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    regwrite_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .DEPTH       (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_regwrite (wb_regwrite),
        .wb_memtoreg (wb_memtoreg),
        .wb_readdata (wb_readdata),
        .wb_aluresult(wb_aluresult),
        .wb_dst      (wb_dst),
        .mdu_valid   (mdu_valid),
        .mdu_dst     (mdu_dst),
        .mdu_data    (mdu_data),
        .mdu_ready   (mdu_ready),
        .pipe_stall  (pipe_stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          due;
    } wr_t;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
    } ent_t;

    wr_t         exp_q[$];
    ent_t        mdu_q[$];
    int          waited = 0;
    int          cycle = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    bit          last_stall = 1'b0;
    wr_t         mon_w;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the scoreboard head in the cycle it is due
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    check("rf_we_unexpected", 32'(rf_we), 32'd0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("write_cycle", 32'(cycle), 32'(mon_w.due));
                    check("rf_waddr", 32'(rf_waddr), 32'(mon_w.addr));
                    check("rf_wdata", rf_wdata, mon_w.data);
                    last_addr = mon_w.addr;
                    last_data = mon_w.data;
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cycle) begin
                check("rf_we_missing", 32'(rf_we), 32'd1);
                void'(exp_q.pop_front());
            end else begin
                check("rf_waddr_hold", 32'(rf_waddr), 32'(last_addr));
                check("rf_wdata_hold", rf_wdata, last_data);
            end
        end
    end

    // One cycle of stimulus plus the reference model's decision for that cycle
    task automatic step(input logic rw, input logic mtr, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [4:0] dst, input logic mv,
                        input logic [4:0] mdst, input logic [31:0] mdat);
        bit   ready;
        bit   preq;
        bit   force_now;
        bit   hgrant;
        wr_t  w;
        ent_t e;
        @(negedge clk);
        #1;
        wb_regwrite  = rw;
        wb_memtoreg  = mtr;
        wb_readdata  = rd;
        wb_aluresult = alu;
        wb_dst       = dst;
        mdu_valid    = mv;
        mdu_dst      = mdst;
        mdu_data     = mdat;
        #1;
        ready     = (mdu_q.size() < DEPTH);
        preq      = rw && (dst != 5'd0);
        force_now = GUARD && (mdu_q.size() > 0) && (waited >= STARVE_LIMIT);
        check("mdu_ready", 32'(mdu_ready), 32'(ready));
        check("pipe_stall", 32'(pipe_stall), 32'(force_now));
        last_stall = force_now;
        hgrant = (mdu_q.size() > 0) && (force_now || !preq);
        if (hgrant) begin
            e = mdu_q.pop_front();
            w.addr = e.dst;
            w.data = e.data;
            w.due  = cycle + 1;
            exp_q.push_back(w);
            waited = 0;
        end else begin
            if (preq) begin
                w.addr = dst;
                w.data = mtr ? rd : alu;
                w.due  = cycle + 1;
                exp_q.push_back(w);
            end
            if (mdu_q.size() > 0) waited++;
            else waited = 0;
        end
        if (mv && ready && mdst != 5'd0) begin
            e.dst  = mdst;
            e.data = mdat;
            mdu_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        #1;
        rst_n       = 1'b0;
        wb_regwrite = 1'b0;
        mdu_valid   = 1'b0;
        #1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        mdu_q.delete();
        exp_q.delete();
        waited     = 0;
        last_addr  = '0;
        last_data  = '0;
        last_stall = 1'b0;
        repeat (hold) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_mdu_ready", 32'(mdu_ready), 32'd1);
        check("post_rst_pipe_stall", 32'(pipe_stall), 32'd0);
    endtask

    logic [31:0] d;
    logic        r_rw, r_mtr, r_mv;
    logic [31:0] r_rd, r_alu, r_md;
    logic [4:0]  r_dst, r_mdst;
    int          pct;

    initial begin
        do_reset(2);

        // Pipeline load result to r8
        step(1'b1, 1'b1, 32'hDEADBEEF, 32'h11111111, 5'd8, 1'b0, '0, '0);
        step(1'b1, 1'b0, 32'hDEADBEEF, 32'h0000CAFE, 5'd7, 1'b0, '0, '0);
        idle(1);

        // MDU result while pipeline idle lands two cycles later
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 5'd9, 32'h12);
        idle(3);

        // Writes to $0 from both sources are dropped
        step(1'b1, 1'b0, '0, 32'h55, 5'd0, 1'b1, 5'd0, 32'h99);
        idle(2);

        // Continuous pipeline writes to r3 while MDU results queue up
        d = 32'h3000_0000;
        for (int i = 0; i < 14; i++) begin
            if (!last_stall) d = d + 32'd1;
            step(1'b1, 1'b0, '0, d, 5'd3, (i < 3), 5'(10 + i), 32'hA0 + 32'(i));
        end
        idle(4);

        // Same-register ordering: buffered r5 followed by pipeline r5
        step(1'b1, 1'b0, '0, 32'h501, 5'd5, 1'b1, 5'd5, 32'h502);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 32'h503, 5'd5, 1'b0, '0, '0);
        idle(3);

        // Reset with two entries buffered discards them
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0, 32'h700 + 32'(i), 5'd3, 1'b1, 5'(20 + i), 32'h800 + 32'(i));
        end
        do_reset(2);
        idle(6);

        // Randomized traffic, alternating heavy and light pipeline load
        for (int i = 0; i < 3000; i++) begin
            pct = ((i / 400) % 2 == 0) ? 90 : 35;
            if (!last_stall) begin
                r_rw  = ($urandom_range(0, 99) < pct);
                r_mtr = $urandom_range(0, 1) == 1;
                r_rd  = $urandom;
                r_alu = $urandom;
                r_dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            end
            r_mv   = $urandom_range(0, 1) == 1;
            r_mdst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r_md   = $urandom;
            step(r_rw, r_mtr, r_rd, r_alu, r_dst, r_mv, r_mdst, r_md);
            if (i == 1500) do_reset(1);
        end
        idle(20);
        check("final_mdu_ready", 32'(mdu_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
